// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, the hard-zero address and the controller state
// encoding for the register-file controller slice.
package regfile_pkg;

    localparam int unsigned AW_DEF = 6;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned WAIT_W = 8;

    localparam logic [AW_DEF-1:0] ZERO_ADDR = '0;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DBG   = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: core pipeline and debug/host access bundle.
//  master : core + debug requester (drives addresses, write requests, dbg_req)
//  slave  : regfile_ctrl (returns read data, core_stall, dbg_ack, dbg_rdata)
interface regfile_ctrl_if
    import regfile_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic [AW-1:0] core_raddr1;
    logic [AW-1:0] core_raddr2;
    logic          core_wen;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic [DW-1:0] core_rdata1;
    logic [DW-1:0] core_rdata2;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;

    modport master (
        output core_raddr1, core_raddr2, core_wen, core_waddr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  core_stall, core_rdata1, core_rdata2, dbg_ack, dbg_rdata
    );

    modport slave (
        input  core_raddr1, core_raddr2, core_wen, core_waddr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output core_stall, core_rdata1, core_rdata2, dbg_ack, dbg_rdata
    );
endinterface

// File: rtl/regfile_dbg_arb.sv
// regfile_dbg_arb: debug access arbitration against core traffic.
//  clk, rst        : clock, async active-high reset
//  en              : controller is in RUN (grants allowed)
//  dbg_req, dbg_we : pending debug request and its direction
//  core_wen        : core writeback request this cycle
//  rd2_val         : masked/bypassed read-port-2 value for the previous issue
//  grant, stall    : grant this cycle / core must be stalled this cycle
//  dbg_ack         : one-cycle completion pulse (cycle after grant)
//  dbg_rdata       : debug read data, valid with dbg_ack on reads
module regfile_dbg_arb
    import regfile_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic          core_wen,
    input  logic [DW-1:0] rd2_val,
    output logic          grant,
    output logic          stall,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata
);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic              ack_q;
    logic              rd_q;
    logic              forced;

    assign forced = (wait_cnt == WAIT_MAX);

    // The core has no read-valid, so a debug read takes port 2 at once and
    // stalls the core; a debug write waits for an idle write port or MAX_WAIT.
    always_comb begin
        grant = 1'b0;
        stall = 1'b0;
        if (en && dbg_req) begin
            if (!dbg_we) begin
                grant = 1'b1;
                stall = 1'b1;
            end else if (!core_wen || forced) begin
                grant = 1'b1;
                stall = core_wen;
            end
        end
    end

    // Wait counter and completion registers; the ack cycle itself never counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            ack_q <= grant;
            rd_q  <= grant && !dbg_we;
            if (grant) begin
                wait_cnt <= '0;
            end else if (dbg_req && !ack_q && !forced) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    assign dbg_ack   = ack_q;
    assign dbg_rdata = (ack_q && rd_q) ? rd2_val : '0;

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: controller for a 2R1W block-RAM register file.
//  Post-reset sweep writes CLEAR_VAL to every entry, x0 reads as zero, and the
//  write port / read port 2 are shared between core writeback and debug.
//  clk, rst   : clock, async active-high reset
//  ready      : sweep done, traffic accepted
//  bus        : regfile_ctrl_if.slave (core + debug signals)
//  ram_*      : RAM drive (write port, two read addresses) and registered read data
//  Optional macro REGFILE_BYPASS_EN: same-cycle write->read forwarding.
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned   AW        = AW_DEF,
    parameter int unsigned   DW        = DW_DEF,
    parameter logic [DW-1:0] CLEAR_VAL = '0,
    parameter int unsigned   MAX_WAIT  = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ready,
    regfile_ctrl_if.slave bus,
    output logic          ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr1,
    output logic [AW-1:0] ram_raddr2,
    input  logic [DW-1:0] ram_rdata1,
    input  logic [DW-1:0] ram_rdata2
);
    localparam logic [AW-1:0] ZA       = AW'(ZERO_ADDR);
    localparam logic [AW-1:0] LAST_PTR = '1;

    state_t        state, state_nx;
    logic [AW-1:0] ptr;
    logic [AW-1:0] raddr1_q, raddr2_q;
    logic          dbg_grant, dbg_stall, dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          core_stall;
    logic [DW-1:0] rd1_val, rd2_val;

    regfile_dbg_arb #(.DW(DW), .MAX_WAIT(MAX_WAIT)) u_dbg_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state == RUN),
        .dbg_req   (bus.dbg_req),
        .dbg_we    (bus.dbg_we),
        .core_wen  (bus.core_wen),
        .rd2_val   (rd2_val),
        .grant     (dbg_grant),
        .stall     (dbg_stall),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata)
    );

    // State register, sweep pointer and ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nx;
            ready <= (state_nx != CLEAR);
            if (state == CLEAR) begin
                ptr <= ptr + AW'(1);
            end
        end
    end

    // Next state and RAM port muxing.
    always_comb begin
        state_nx   = state;
        ram_wen    = 1'b0;
        ram_waddr  = bus.core_waddr;
        ram_wdata  = bus.core_wdata;
        ram_raddr1 = bus.core_raddr1;
        ram_raddr2 = bus.core_raddr2;
        core_stall = 1'b0;
        case (state)
            CLEAR: begin
                ram_wen    = 1'b1;
                ram_waddr  = ptr;
                ram_wdata  = CLEAR_VAL;
                ram_raddr1 = ZA;
                ram_raddr2 = ZA;
                core_stall = 1'b1;
                if (ptr == LAST_PTR) begin
                    state_nx = RUN;
                end
            end
            RUN, DBG: begin
                core_stall = dbg_stall;
                if (dbg_grant && bus.dbg_we) begin
                    ram_wen   = (bus.dbg_addr != ZA);
                    ram_waddr = bus.dbg_addr;
                    ram_wdata = bus.dbg_wdata;
                end else if (bus.core_wen && !dbg_stall) begin
                    ram_wen = (bus.core_waddr != ZA);
                end
                if (dbg_grant && !bus.dbg_we) begin
                    ram_raddr2 = bus.dbg_addr;
                end
                state_nx = dbg_grant ? DBG : RUN;
            end
            default: state_nx = CLEAR;
        endcase
        // Nothing reaches the RAM while reset is held.
        if (rst) begin
            ram_wen    = 1'b0;
            core_stall = 1'b1;
        end
    end

    // Issue-cycle read addresses, used for x0 masking (and bypass compare).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr1_q <= '0;
            raddr2_q <= '0;
        end else begin
            raddr1_q <= ram_raddr1;
            raddr2_q <= ram_raddr2;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic          byp_wen_q;
    logic [AW-1:0] byp_waddr_q;
    logic [DW-1:0] byp_wdata_q;

    // Last committed write, forwarded over the RAM's old read-during-write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_wen_q   <= 1'b0;
            byp_waddr_q <= '0;
            byp_wdata_q <= '0;
        end else begin
            byp_wen_q   <= ram_wen;
            byp_waddr_q <= ram_waddr;
            byp_wdata_q <= ram_wdata;
        end
    end

    assign rd1_val = (raddr1_q == ZA) ? '0 :
                     (byp_wen_q && byp_waddr_q == raddr1_q) ? byp_wdata_q : ram_rdata1;
    assign rd2_val = (raddr2_q == ZA) ? '0 :
                     (byp_wen_q && byp_waddr_q == raddr2_q) ? byp_wdata_q : ram_rdata2;
`else
    assign rd1_val = (raddr1_q == ZA) ? '0 : ram_rdata1;
    assign rd2_val = (raddr2_q == ZA) ? '0 : ram_rdata2;
`endif

    assign bus.core_stall  = core_stall;
    assign bus.core_rdata1 = rd1_val;
    assign bus.core_rdata2 = rd2_val;
    assign bus.dbg_ack     = dbg_ack;
    assign bus.dbg_rdata   = dbg_rdata;

endmodule
